// File: rtl/proc_stream_loader_if.sv
// Stream and processor-BRAM bus bundle for proc_stream_loader.
// The master modport is the loader side; slave is the host/processor side.
interface proc_stream_loader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned OP_WIDTH   = 3
);
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_valid_i;
  logic                  s_ready_o;

  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_ready_i;

  logic [DATA_WIDTH-1:0] p_data_o;
  logic [ADDR_WIDTH-1:0] p_addr_data_o;
  logic                  p_ena_a_o;
  logic                  p_wea_a_o;
  logic                  p_ena_b_o;
  logic                  p_wea_b_o;
  logic                  p_ena_res_o;
  logic                  p_wea_res_o;
  logic [DATA_WIDTH-1:0] p_data_i;
  logic [OP_WIDTH-1:0]   p_op_o;
  logic [ADDR_WIDTH-1:0] p_addr_op_o;
  logic                  p_ena_op_o;
  logic                  p_wea_op_o;
  logic                  p_start_o;
  logic                  p_done_i;

  modport master (
    input  s_data_i, s_valid_i,
    output s_ready_o,
    output m_data_o, m_valid_o,
    input  m_ready_i,
    output p_data_o, p_addr_data_o,
    output p_ena_a_o, p_wea_a_o, p_ena_b_o, p_wea_b_o,
    output p_ena_res_o, p_wea_res_o,
    input  p_data_i,
    output p_op_o, p_addr_op_o, p_ena_op_o, p_wea_op_o,
    output p_start_o,
    input  p_done_i
  );

  modport slave (
    output s_data_i, s_valid_i,
    input  s_ready_o,
    input  m_data_o, m_valid_o,
    output m_ready_i,
    input  p_data_o, p_addr_data_o,
    input  p_ena_a_o, p_wea_a_o, p_ena_b_o, p_wea_b_o,
    input  p_ena_res_o, p_wea_res_o,
    output p_data_i,
    input  p_op_o, p_addr_op_o, p_ena_op_o, p_wea_op_o,
    input  p_start_o,
    output p_done_i
  );
endinterface

// File: rtl/proc_stream_loader.sv
// Host-side sequencer: loads A/B/op BRAMs from a stream, runs the processor, streams results back.
// Optional PROC_LOADER_CHECKSUM_EN adds checksum_o, the per-job sum of accepted result words.
module proc_stream_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned OP_WIDTH   = 3,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  proc_stream_loader_if.master  ldr,
  output logic                  busy_o,
  output logic                  job_done_o
`ifdef PROC_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum_o
`endif
);

  localparam int unsigned     IDX_W    = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [3:0] {
    LOAD_A,
    LOAD_B,
    LOAD_OP,
    SETTLE,
    RUN,
    RELEASE,
    RD_REQ,
    RD_WAIT,
    RD_OUT
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             loading;
  logic             xfer;
  logic             accept;
  logic             last;

  assign ldr.s_ready_o   = RST && loading;
  assign ldr.p_wea_res_o = 1'b0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= LOAD_A;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  always_comb begin
    loading = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_OP);
    xfer    = ldr.s_valid_i && ldr.s_ready_o;
    accept  = (state == RD_OUT) && ldr.m_valid_o && ldr.m_ready_i;
    last    = (idx == IDX_LAST);
    busy_o  = !((state == LOAD_A) && (idx == '0));
    state_d = state;
    idx_d   = idx;
    unique case (state)
      LOAD_A, LOAD_B, LOAD_OP: begin
        if (xfer) begin
          if (last) begin
            idx_d   = '0;
            state_d = (state == LOAD_A) ? LOAD_B :
                      ((state == LOAD_B) ? LOAD_OP : SETTLE);
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end
      SETTLE:  state_d = RUN;
      RUN:     if (ldr.p_done_i)  state_d = RELEASE;
      RELEASE: if (!ldr.p_done_i) state_d = RD_REQ;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: state_d = RD_OUT;
      RD_OUT: begin
        if (accept) begin
          if (last) begin
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            idx_d   = idx + IDX_W'(1);
            state_d = RD_REQ;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = LOAD_A;
      end
    endcase
  end

  // Registered outputs are computed from the next state so that start,
  // read enable and result valid line up exactly with the state they belong to.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ldr.p_data_o      <= '0;
      ldr.p_addr_data_o <= '0;
      ldr.p_ena_a_o     <= 1'b0;
      ldr.p_wea_a_o     <= 1'b0;
      ldr.p_ena_b_o     <= 1'b0;
      ldr.p_wea_b_o     <= 1'b0;
      ldr.p_ena_res_o   <= 1'b0;
      ldr.p_op_o        <= '0;
      ldr.p_addr_op_o   <= '0;
      ldr.p_ena_op_o    <= 1'b0;
      ldr.p_wea_op_o    <= 1'b0;
      ldr.p_start_o     <= 1'b0;
      ldr.m_data_o      <= '0;
      ldr.m_valid_o     <= 1'b0;
      job_done_o        <= 1'b0;
    end else begin
      ldr.p_ena_a_o   <= 1'b0;
      ldr.p_wea_a_o   <= 1'b0;
      ldr.p_ena_b_o   <= 1'b0;
      ldr.p_wea_b_o   <= 1'b0;
      ldr.p_ena_op_o  <= 1'b0;
      ldr.p_wea_op_o  <= 1'b0;
      ldr.p_start_o   <= (state_d == RUN);
      ldr.p_ena_res_o <= (state_d == RD_REQ);
      ldr.m_valid_o   <= (state_d == RD_OUT);
      job_done_o      <= accept && last;

      if (state_d == RD_REQ) begin
        ldr.p_addr_data_o <= idx_d[ADDR_WIDTH-1:0];
      end

      if (xfer) begin
        unique case (state)
          LOAD_A: begin
            ldr.p_data_o      <= ldr.s_data_i;
            ldr.p_addr_data_o <= idx[ADDR_WIDTH-1:0];
            ldr.p_ena_a_o     <= 1'b1;
            ldr.p_wea_a_o     <= 1'b1;
          end
          LOAD_B: begin
            ldr.p_data_o      <= ldr.s_data_i;
            ldr.p_addr_data_o <= idx[ADDR_WIDTH-1:0];
            ldr.p_ena_b_o     <= 1'b1;
            ldr.p_wea_b_o     <= 1'b1;
          end
          LOAD_OP: begin
            ldr.p_op_o      <= ldr.s_data_i[OP_WIDTH-1:0];
            ldr.p_addr_op_o <= idx[ADDR_WIDTH-1:0];
            ldr.p_ena_op_o  <= 1'b1;
            ldr.p_wea_op_o  <= 1'b1;
          end
          default: ;
        endcase
      end

      if (state == RD_WAIT) begin
        ldr.m_data_o <= ldr.p_data_i;
      end
    end
  end

`ifdef PROC_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;

  // The final word is folded in while latching, so checksum_o covers the whole job.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sum_q      <= '0;
      checksum_o <= '0;
    end else if (accept) begin
      if (last) begin
        checksum_o <= sum_q + ldr.m_data_o;
        sum_q      <= '0;
      end else begin
        sum_q <= sum_q + ldr.m_data_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_proc_stream_loader.sv
// Directed bench for proc_stream_loader with write/result scoreboards and a processor model.
module tb_proc_stream_loader;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 3;
  localparam int unsigned OW    = 3;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic busy_o;
  logic job_done_o;
`ifdef PROC_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum_o;
`endif

  proc_stream_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) bus ();

  proc_stream_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .OP_WIDTH(OW),
    .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ldr(bus),
    .busy_o(busy_o),
    .job_done_o(job_done_o)
`ifdef PROC_LOADER_CHECKSUM_EN
    ,
    .checksum_o(checksum_o)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Processor model: result BRAM with 1-cycle read latency, done 5 cycles after start.
  logic [DW-1:0] mem_r [8];
  logic [DW-1:0] rd_q = '0;
  logic          done_model = 1'b0;
  logic          done_force = 1'b0;
  int unsigned   dcnt = 0;

  assign bus.p_data_i = rd_q;
  assign bus.p_done_i = done_model | done_force;

  always @(posedge CLK) begin
    if (bus.p_ena_res_o && !bus.p_wea_res_o) rd_q <= mem_r[bus.p_addr_data_o];
  end

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      done_model <= 1'b0;
      dcnt       <= 0;
    end else if (bus.p_start_o && !done_model) begin
      if (dcnt == 4) begin
        done_model <= 1'b1;
        dcnt       <= 0;
      end else begin
        dcnt <= dcnt + 1;
      end
    end else if (!bus.p_start_o) begin
      done_model <= 1'b0;
    end
  end

  // Scoreboards and monitors
  wr_t           wq[$];
  logic [DW-1:0] rq[$];
  int unsigned   gaps[$];
  int unsigned   cyc = 0;
  int unsigned   last_cyc = 0;
  bit            first_acc = 1'b1;
  int unsigned   acc_total = 0;
  int unsigned   jd_count = 0;
  int unsigned   jd_target = 0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (RST && (bus.p_ena_a_o || bus.p_ena_b_o || bus.p_ena_op_o)) begin
      if (wq.size() == 0) begin
        chk("write_unexpected", {bus.p_ena_op_o, bus.p_ena_b_o, bus.p_ena_a_o}, 0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("write_sel", {bus.p_ena_op_o, bus.p_wea_op_o, bus.p_ena_b_o, bus.p_wea_b_o,
                          bus.p_ena_a_o, bus.p_wea_a_o}, 6'b000011 << (2 * e.kind));
        if (e.kind == 2) begin
          chk("write_op_addr", bus.p_addr_op_o, e.addr);
          chk("write_op_data", bus.p_op_o, e.data);
        end else begin
          chk("write_addr", bus.p_addr_data_o, e.addr);
          chk("write_data", bus.p_data_o, e.data);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RST && bus.m_valid_o && bus.m_ready_i) begin
      if (rq.size() == 0) begin
        chk("result_unexpected", bus.m_valid_o, 1'b0);
      end else begin
        chk("result_data", bus.m_data_o, rq.pop_front());
        chk("result_res_bram", {bus.p_ena_res_o, bus.p_wea_res_o}, 2'b00);
      end
      if (!first_acc) gaps.push_back(cyc - last_cyc);
      first_acc = 1'b0;
      last_cyc  = cyc;
      acc_total++;
    end
    if (job_done_o) jd_count++;
  end

  function automatic logic cond(input int unsigned which, input int unsigned target);
    case (which)
      0: return bus.m_valid_o;
      1: return jd_count == target;
      2: return acc_total == target;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_neg(input int unsigned which, input int unsigned target, input string tag);
    int unsigned n = 0;
    @(negedge CLK);
    while (!cond(which, target) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, cond(which, target), 1'b1);
  endtask

  task automatic send(input int unsigned kind, input int unsigned addr, input logic [DW-1:0] d);
    int unsigned n = 0;
    wr_t e;
    bus.s_data_i  = d;
    bus.s_valid_i = 1'b1;
    @(negedge CLK);
    while (!bus.s_ready_o && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("s_ready_load", bus.s_ready_o, 1'b1);
    e.kind = 2'(kind);
    e.addr = AW'(addr);
    e.data = (kind == 2) ? (d & 32'h7) : d;
    wq.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic run_load(input logic [3:0][DW-1:0] a, input logic [3:0][DW-1:0] b,
                          input logic [3:0][DW-1:0] op, input logic [3:0][DW-1:0] res,
                          input bit toggle_b);
    for (int i = 0; i < 4; i++) begin
      mem_r[i] = res[i];
      rq.push_back(res[i]);
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) send(0, i, a[i]);
    for (int i = 0; i < 4; i++) begin
      send(1, i, b[i]);
      if (toggle_b) begin
        bus.s_valid_i = 1'b0;
        @(posedge CLK);
        #1;
      end
    end
    for (int i = 0; i < 4; i++) send(2, i, op[i]);
    bus.s_valid_i = 1'b0;
  endtask

  initial begin
    bus.s_data_i  = '0;
    bus.s_valid_i = 1'b0;
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) mem_r[i] = '0;

    // Reset state
    #2 RST = 1'b0;
    #1;
    chk("rst_s_ready", bus.s_ready_o, 1'b0);
    chk("rst_m_valid", bus.m_valid_o, 1'b0);
    chk("rst_m_data", bus.m_data_o, 0);
    chk("rst_p_outs", {bus.p_ena_a_o, bus.p_wea_a_o, bus.p_ena_b_o, bus.p_wea_b_o,
                       bus.p_ena_op_o, bus.p_wea_op_o, bus.p_ena_res_o, bus.p_start_o}, 0);
    chk("rst_busy_done", {busy_o, job_done_o}, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("idle_s_ready", bus.s_ready_o, 1'b1);
    chk("idle_busy", busy_o, 1'b0);

    // Job 1: continuous load; done held high during load must be ignored
    done_force = 1'b1;
    first_acc  = 1'b1;
    bus.m_ready_i = 1'b1;
    jd_target = 1;
    run_load({32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
             {32'd0, 32'd0, 32'd0, 32'd0}, {32'd44, 32'd33, 32'd22, 32'd11}, 1'b0);
    done_force = 1'b0;
    @(negedge CLK);
    chk("settle_s_ready", bus.s_ready_o, 1'b0);
    chk("settle_start", bus.p_start_o, 1'b0);
    chk("settle_busy", busy_o, 1'b1);
    @(negedge CLK);
    chk("run_start", bus.p_start_o, 1'b1);
    wait_neg(1, jd_target, "job1_done_timeout");
    repeat (2) @(negedge CLK);
    chk("job1_pulse_count", jd_count, 1);
    chk("job1_start_low", bus.p_start_o, 1'b0);
    chk("job1_m_valid_low", bus.m_valid_o, 1'b0);
    chk("job1_gap_count", gaps.size(), 3);
    for (int i = 0; i < 3 && i < gaps.size(); i++) chk("job1_gap", gaps[i], 3);
`ifdef PROC_LOADER_CHECKSUM_EN
    chk("job1_checksum", checksum_o, 110);
`endif

    // Job 2: s_valid toggling in LOAD_B, 7-cycle stall on word 2
    jd_target = 2;
    run_load({32'd8, 32'd7, 32'd6, 32'd5}, {32'd80, 32'd70, 32'd60, 32'd50},
             {32'hC, 32'hB, 32'hA, 32'h9}, {32'd44, 32'd33, 32'd22, 32'd11}, 1'b1);
    wait_neg(2, 5, "job2_first_acc_timeout");
    @(posedge CLK);
    #1 bus.m_ready_i = 1'b0;
    wait_neg(0, 0, "job2_valid_timeout");
    for (int i = 0; i < 7; i++) begin
      chk("stall_valid", bus.m_valid_o, 1'b1);
      chk("stall_data", bus.m_data_o, 22);
      chk("stall_addr", bus.p_addr_data_o, 1);
      chk("stall_res_ena", bus.p_ena_res_o, 1'b0);
`ifdef PROC_LOADER_CHECKSUM_EN
      chk("stall_checksum_hold", checksum_o, 110);
`endif
      @(negedge CLK);
    end
    @(posedge CLK);
    #1 bus.m_ready_i = 1'b1;
    wait_neg(1, jd_target, "job2_done_timeout");
`ifdef PROC_LOADER_CHECKSUM_EN
    chk("job2_checksum", checksum_o, 110);
`endif

    // Job 3: back-to-back, results of ones
    jd_target = 3;
    run_load({32'd0, 32'd0, 32'd0, 32'd0}, {32'd1, 32'd1, 32'd1, 32'd1},
             {32'd0, 32'd0, 32'd0, 32'd0}, {32'd1, 32'd1, 32'd1, 32'd1}, 1'b0);
    wait_neg(1, jd_target, "job3_done_timeout");
`ifdef PROC_LOADER_CHECKSUM_EN
    chk("job3_checksum", checksum_o, 4);
`endif

    // Job 4: reset while holding in RD_OUT
    bus.m_ready_i = 1'b0;
    run_load({32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8},
             {32'd1, 32'd2, 32'd3, 32'd4}, {32'd99, 32'd98, 32'd97, 32'd96}, 1'b0);
    wait_neg(0, 0, "job4_valid_timeout");
    #2 RST = 1'b0;
    rq.delete();
    #1;
    chk("abort_m_valid", bus.m_valid_o, 1'b0);
    chk("abort_m_data", bus.m_data_o, 0);
    chk("abort_start", bus.p_start_o, 1'b0);
    chk("abort_s_ready", bus.s_ready_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
`ifdef PROC_LOADER_CHECKSUM_EN
    chk("abort_checksum", checksum_o, 0);
`endif
    @(posedge CLK);
    #1 RST = 1'b1;
    bus.m_ready_i = 1'b1;

    // Job 5: restarts from address 0 and completes normally
    jd_target = 4;
    run_load({32'd3, 32'd2, 32'd1, 32'd0}, {32'd7, 32'd6, 32'd5, 32'd4},
             {32'd7, 32'd6, 32'd5, 32'd4}, {32'd10, 32'd9, 32'd8, 32'd7}, 1'b0);
    wait_neg(1, jd_target, "job5_done_timeout");
    repeat (2) @(negedge CLK);
    chk("job5_pulse_count", jd_count, 4);
`ifdef PROC_LOADER_CHECKSUM_EN
    chk("job5_checksum", checksum_o, 34);
`endif
    chk("writes_drained", wq.size(), 0);
    chk("results_drained", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
